branch_target_predictor: RTL and testbench

- Responder side of the fetch-stage prediction interface. Fetch drives lookup_PC; this block answers in the same cycle with BTB_hit, BTB_PC and is_branch_predict.
- Direct-mapped branch target buffer with one 2-bit saturating direction counter per entry.
- Trained by the execute stage when each branch/jump resolves. Also keeps two saturating statistics counters.

---
 rtl/branch_target_predictor_pkg.sv | 29 ++
 rtl/branch_target_predictor_sat_counter2.sv | 22 ++
 rtl/branch_target_predictor.sv | 139 +++++++++++++
 tb/tb_branch_target_predictor.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/branch_target_predictor_pkg.sv
// Shared constants, counter encodings and helpers for the branch predictors.
package branch_target_predictor_pkg;

  localparam int BTB_INDEX_W = 6;
  localparam int BTB_TAG_W   = 24;

  // 2-bit direction counter encodings
  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_e;

  // New entries start weakly taken: they were allocated by a taken branch.
  localparam logic [1:0] CTR_INIT = 2'b10;

  // 32-bit increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] value);
    logic [31:0] result;
    if (value == 32'hFFFF_FFFF) begin
      result = value;
    end else begin
      result = value + 32'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/branch_target_predictor_sat_counter2.sv
// 2-bit saturating up/down counter next-state function (taken = up).
module sat_counter2
  import branch_target_predictor_pkg::*;
(
  input  logic [1:0] i_ctr,
  input  logic       i_taken,
  output logic [1:0] o_ctr_next
);

  // Step one state toward the resolved direction, holding at the ends.
  always_comb begin
    o_ctr_next = i_ctr;
    case (i_ctr)
      CTR_SNT: o_ctr_next = i_taken ? CTR_WNT : CTR_SNT;
      CTR_WNT: o_ctr_next = i_taken ? CTR_WT  : CTR_SNT;
      CTR_WT:  o_ctr_next = i_taken ? CTR_ST  : CTR_WNT;
      CTR_ST:  o_ctr_next = i_taken ? CTR_ST  : CTR_WT;
      default: o_ctr_next = i_ctr;
    endcase
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Fetch looks up combinationally; execute trains on branch resolution.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int         INDEX_W  = branch_target_predictor_pkg::BTB_INDEX_W,
  parameter int         TAG_W    = branch_target_predictor_pkg::BTB_TAG_W,
  parameter logic [1:0] CTR_INIT = branch_target_predictor_pkg::CTR_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_PC,
  output logic        BTB_hit,
  output logic [31:0] BTB_PC,
  output logic        is_branch_predict,
  input  logic        update_valid,
  input  logic [31:0] update_PC,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_mispredict,
  input  logic        flush,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
);

  localparam int ENTRIES = 1 << INDEX_W;

  // Table storage; only valid and ctr are reset.
  logic [ENTRIES-1:0] r_valid;
  logic [1:0]         r_ctr    [ENTRIES];
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [31:0]        r_target [ENTRIES];

  logic [31:0] r_stat_updates;
  logic [31:0] r_stat_mispredicts;

  logic [INDEX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0]   w_lk_tag;
  logic               w_lk_hit;

  logic [INDEX_W-1:0] w_up_idx;
  logic [TAG_W-1:0]   w_up_tag;
  logic               w_up_hit;
  logic               w_up_accept;
  logic               w_alloc;
  logic               w_train;
  logic [1:0]         w_up_ctr;
  logic [1:0]         w_ctr_next;

  // Word-offset bits play no part in indexing or tagging.
  logic w_unused;
  assign w_unused = ^{lookup_PC[1:0], update_PC[1:0]};

  assign w_lk_idx = lookup_PC[INDEX_W+1:2];
  assign w_lk_tag = lookup_PC[31:INDEX_W+2];
  assign w_up_idx = update_PC[INDEX_W+1:2];
  assign w_up_tag = update_PC[31:INDEX_W+2];

  // Zero-latency lookup against the current (pre-update) table contents.
  always_comb begin
    w_lk_hit          = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    BTB_hit           = w_lk_hit;
    is_branch_predict = 1'b0;
    BTB_PC            = 32'h0000_0000;
    if (w_lk_hit) begin
      BTB_PC            = r_target[w_lk_idx];
      is_branch_predict = r_ctr[w_lk_idx][1];
    end else begin
      BTB_PC            = 32'h0000_0000;
      is_branch_predict = 1'b0;
    end
  end

  // Classify the resolving branch: train a hit, allocate a taken miss.
  always_comb begin
    w_up_hit    = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);
    w_up_ctr    = r_ctr[w_up_idx];
    w_up_accept = update_valid && !flush;
    w_alloc     = 1'b0;
    w_train     = 1'b0;
    if (w_up_accept) begin
      w_alloc = update_taken && !w_up_hit;
      w_train = w_up_hit;
    end else begin
      w_alloc = 1'b0;
      w_train = 1'b0;
    end
  end

  sat_counter2 u_sat_counter2 (
    .i_ctr      (w_up_ctr),
    .i_taken    (update_taken),
    .o_ctr_next (w_ctr_next)
  );

  // Valid bits and direction counters: reset, flush, allocate or train.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= {ENTRIES{1'b0}};
      for (int i = 0; i < ENTRIES; i++) begin
        r_ctr[i] <= CTR_INIT;
      end
    end else if (flush) begin
      r_valid <= {ENTRIES{1'b0}};
    end else if (w_alloc) begin
      r_valid[w_up_idx] <= 1'b1;
      r_ctr[w_up_idx]   <= CTR_INIT;
    end else if (w_train) begin
      r_ctr[w_up_idx]   <= w_ctr_next;
    end
  end

  // Tag and target payload; stale contents are harmless behind a clear valid bit.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= update_target;
    end else if (w_train && update_taken) begin
      r_target[w_up_idx] <= update_target;
    end
  end

  // Saturating statistics over accepted updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stat_updates     <= 32'h0000_0000;
      r_stat_mispredicts <= 32'h0000_0000;
    end else if (w_up_accept) begin
      r_stat_updates <= sat_inc32(r_stat_updates);
      if (update_mispredict) begin
        r_stat_mispredicts <= sat_inc32(r_stat_mispredicts);
      end
    end
  end

  assign stat_updates     = r_stat_updates;
  assign stat_mispredicts = r_stat_mispredicts;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor.
module tb_branch_target_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_PC;
  logic        BTB_hit;
  logic [31:0] BTB_PC;
  logic        is_branch_predict;
  logic        update_valid;
  logic [31:0] update_PC;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic        flush;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;

  int n_pass  = 0;
  int n_total = 0;

  branch_target_predictor dut (
    .clk               (clk),
    .rst               (rst),
    .lookup_PC         (lookup_PC),
    .BTB_hit           (BTB_hit),
    .BTB_PC            (BTB_PC),
    .is_branch_predict (is_branch_predict),
    .update_valid      (update_valid),
    .update_PC         (update_PC),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .flush             (flush),
    .stat_updates      (stat_updates),
    .stat_mispredicts  (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a lookup and compare all three answer outputs.
  task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                      input logic [31:0] tgt, input logic pred);
    lookup_PC = pc;
    #1;
    check({tag, ".hit"},  {31'd0, BTB_hit}, {31'd0, hit});
    check({tag, ".pc"},   BTB_PC, tgt);
    check({tag, ".pred"}, {31'd0, is_branch_predict}, {31'd0, pred});
  endtask

  // One-cycle update pulse.
  task automatic upd(input logic [31:0] pc, input logic taken,
                     input logic [31:0] tgt, input logic mis);
    update_PC         = pc;
    update_taken      = taken;
    update_target     = tgt;
    update_mispredict = mis;
    update_valid      = 1'b1;
    tick();
    update_valid      = 1'b0;
    update_PC         = 32'hxxxx_xxxx;
    update_taken      = 1'bx;
    update_target     = 32'hxxxx_xxxx;
    update_mispredict = 1'bx;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; update_valid = 1'b0;
    update_PC = 32'h0; update_taken = 1'b0; update_target = 32'h0;
    update_mispredict = 1'b0; lookup_PC = 32'h0001_0000;
    tick();
    tick();
    rst = 1'b1;
    tick();

    // Reset state
    look("reset", 32'h0001_0000, 1'b0, 32'h0, 1'b0);
    check("reset.stat_upd", stat_updates, 32'd0);
    check("reset.stat_mis", stat_mispredicts, 32'd0);

    // Allocate on taken miss: ctr = 2 -> predict taken
    upd(32'h0001_0010, 1'b1, 32'h0001_0040, 1'b1);
    look("alloc", 32'h0001_0010, 1'b1, 32'h0001_0040, 1'b1);
    check("alloc.stat_upd", stat_updates, 32'd1);
    check("alloc.stat_mis", stat_mispredicts, 32'd1);

    // Not-taken training: 2 -> 1 -> 0 -> 0
    upd(32'h0001_0010, 1'b0, 32'hDEAD_BEEF, 1'b1);
    look("nt1", 32'h0001_0010, 1'b1, 32'h0001_0040, 1'b0);
    check("nt1.stat_mis", stat_mispredicts, 32'd2);
    upd(32'h0001_0010, 1'b0, 32'hDEAD_BEEF, 1'b0);
    look("nt2", 32'h0001_0010, 1'b1, 32'h0001_0040, 1'b0);
    upd(32'h0001_0010, 1'b0, 32'hDEAD_BEEF, 1'b0);
    look("nt3", 32'h0001_0010, 1'b1, 32'h0001_0040, 1'b0);
    check("nt3.stat_upd", stat_updates, 32'd4);
    check("nt3.stat_mis", stat_mispredicts, 32'd2);

    // Taken from 0 reaches only 1 (proves the floor held), then 2
    upd(32'h0001_0010, 1'b1, 32'h0001_0044, 1'b0);
    look("tk1", 32'h0001_0010, 1'b1, 32'h0001_0044, 1'b0);
    upd(32'h0001_0010, 1'b1, 32'h0001_0048, 1'b0);
    look("tk2", 32'h0001_0010, 1'b1, 32'h0001_0048, 1'b1);

    // Up to 3, hold at 3, then two not-taken: 2 (taken), 1 (not taken)
    upd(32'h0001_0010, 1'b1, 32'h0001_0048, 1'b0);
    upd(32'h0001_0010, 1'b1, 32'h0001_0048, 1'b0);
    upd(32'h0001_0010, 1'b0, 32'h0, 1'b0);
    look("sat_hi1", 32'h0001_0010, 1'b1, 32'h0001_0048, 1'b1);
    upd(32'h0001_0010, 1'b0, 32'h0, 1'b0);
    look("sat_hi2", 32'h0001_0010, 1'b1, 32'h0001_0048, 1'b0);
    check("train.stat_upd", stat_updates, 32'd10);

    // Aliasing: same index 4, tag 0x101 replaces tag 0x100
    upd(32'h0001_0110, 1'b1, 32'h0001_0200, 1'b0);
    look("alias_old", 32'h0001_0010, 1'b0, 32'h0, 1'b0);
    look("alias_new", 32'h0001_0110, 1'b1, 32'h0001_0200, 1'b1);

    // Not taken on a miss leaves the table alone
    upd(32'h0001_0014, 1'b0, 32'h0001_0300, 1'b0);
    look("nt_miss", 32'h0001_0014, 1'b0, 32'h0, 1'b0);
    check("nt_miss.stat_upd", stat_updates, 32'd12);

    // Same-cycle lookup and allocate: no bypass
    lookup_PC = 32'h0001_0020;
    update_PC = 32'h0001_0020; update_taken = 1'b1;
    update_target = 32'h0001_0080; update_mispredict = 1'b0; update_valid = 1'b1;
    #1;
    check("bypass.same_cycle_hit", {31'd0, BTB_hit}, 32'd0);
    tick();
    update_valid = 1'b0;
    look("bypass.next", 32'h0001_0020, 1'b1, 32'h0001_0080, 1'b1);

    // Flush with a concurrent update: everything misses, update dropped
    flush = 1'b1;
    upd(32'h0001_0030, 1'b1, 32'h0001_0090, 1'b1);
    flush = 1'b0;
    look("flush_a", 32'h0001_0020, 1'b0, 32'h0, 1'b0);
    look("flush_b", 32'h0001_0110, 1'b0, 32'h0, 1'b0);
    tick();
    look("flush_c", 32'h0001_0030, 1'b0, 32'h0, 1'b0);
    check("flush.stat_upd", stat_updates, 32'd13);
    check("flush.stat_mis", stat_mispredicts, 32'd2);

    // Re-allocation after flush restarts the counter at weakly taken
    upd(32'h0001_0020, 1'b1, 32'h0001_00A0, 1'b0);
    look("realloc", 32'h0001_0020, 1'b1, 32'h0001_00A0, 1'b1);

    // Statistics saturation
    force dut.r_stat_mispredicts = 32'hFFFF_FFFE;
    #1;
    release dut.r_stat_mispredicts;
    upd(32'h0002_0000, 1'b0, 32'h0, 1'b1);
    check("sat.mis1", stat_mispredicts, 32'hFFFF_FFFF);
    upd(32'h0002_0000, 1'b0, 32'h0, 1'b1);
    check("sat.mis2", stat_mispredicts, 32'hFFFF_FFFF);
    upd(32'h0002_0000, 1'b0, 32'h0, 1'b1);
    check("sat.mis3", stat_mispredicts, 32'hFFFF_FFFF);
    check("sat.stat_upd", stat_updates, 32'd17);

    // Asynchronous reset mid-cycle
    look("pre_rst", 32'h0001_0020, 1'b1, 32'h0001_00A0, 1'b1);
    rst = 1'b0;
    #1;
    check("async_rst.hit",  {31'd0, BTB_hit}, 32'd0);
    check("async_rst.pc",   BTB_PC, 32'd0);
    check("async_rst.pred", {31'd0, is_branch_predict}, 32'd0);
    check("async_rst.stat_upd", stat_updates, 32'd0);
    check("async_rst.stat_mis", stat_mispredicts, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    look("post_rst", 32'h0001_0020, 1'b0, 32'h0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
